om_buffer_ctrl: RTL

- Controller for the overflow-monitor range buffer. The buffer is a circular store of {first,last} address pairs with a combinational in-range lookup.
- Arbitrates range writes from NUM_REQ requesters onto the buffer's single write port. Sequences address checks through the lookup port with a valid/ready response. Drives the buffer's synchronous clear.
- Tracks occupancy, wrap and invalid-range statistics.
- Sits between the core-side allocation/stack trackers and the buffer instance.

---
 rtl/om_pkg.sv | 27 ++
 rtl/om_rr_arbiter.sv | 51 +++++
 rtl/om_buffer_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/om_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | om_pkg: shared types for the overflow-monitor range buffer control.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package om_pkg;

  localparam int OM_ADDR_W = 32;

  typedef struct packed {
    logic [OM_ADDR_W-1:0] first;
    logic [OM_ADDR_W-1:0] last;
  } om_range_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2,
    CLEAR  = 2'd3
  } om_ctrl_state_e;

  function automatic logic om_range_valid(input om_range_t r);
    return r.last >= r.first;
  endfunction

endpackage
`default_nettype wire

// File: rtl/om_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | om_rr_arbiter: round-robin one-hot grant, pointer moves past grantee.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module om_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [PTR_W:0]   w_idx;
  logic             w_found;

  // Scan from the pointer upwards, wrapping at NUM_REQ; first hit wins.
  always_comb begin
    gnt_o     = '0;
    w_ptr_nxt = r_ptr;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = {1'b0, r_ptr} + (PTR_W+1)'(i);
      if (w_idx >= (PTR_W+1)'(NUM_REQ)) begin
        w_idx = w_idx - (PTR_W+1)'(NUM_REQ);
      end
      if (en_i && !w_found && req_i[w_idx[PTR_W-1:0]]) begin
        w_found                    = 1'b1;
        gnt_o[w_idx[PTR_W-1:0]]    = 1'b1;
        w_ptr_nxt = (w_idx == (PTR_W+1)'(NUM_REQ-1)) ? '0 : w_idx[PTR_W-1:0] + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/om_buffer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | om_buffer_ctrl: write arbitration, check sequencing, clear and stats |
// | for the overflow-monitor range buffer.                 Rev 1.0       |
// +----------------------------------------------------------------------+
module om_buffer_ctrl
  import om_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int SIZE    = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 clear_i,
  input  logic [NUM_REQ-1:0]                   wr_req_i,
  input  logic [NUM_REQ-1:0][OM_ADDR_W-1:0]    wr_first_i,
  input  logic [NUM_REQ-1:0][OM_ADDR_W-1:0]    wr_last_i,
  output logic [NUM_REQ-1:0]                   wr_gnt_o,
  input  logic                                 chk_valid_i,
  input  logic [OM_ADDR_W-1:0]                 chk_addr_i,
  output logic                                 chk_ready_o,
  output logic                                 rsp_valid_o,
  output logic                                 rsp_hit_o,
  input  logic                                 rsp_ready_i,
  output logic                                 buf_rst_us_o,
  output logic                                 buf_en_write_o,
  output logic [OM_ADDR_W-1:0]                 buf_addr_first_o,
  output logic [OM_ADDR_W-1:0]                 buf_addr_last_o,
  output logic [OM_ADDR_W-1:0]                 buf_find_addr_o,
  input  logic                                 buf_addr_in_range_i,
  output logic [$clog2(SIZE+1)-1:0]            count_o,
  output logic                                 wrapped_o,
  output logic [CNT_W-1:0]                     err_cnt_o
);

  localparam int COUNT_W = $clog2(SIZE+1);

  om_ctrl_state_e       r_state, w_state_nxt;
  logic                 r_clr_pend, w_pend_nxt;
  logic                 r_live;
  logic                 w_chk_ready;
  logic                 w_gnt_en;
  logic [NUM_REQ-1:0]   w_gnt;
  om_range_t            w_wr_range, r_wr_range;
  logic                 w_wr_any, w_wr_ok, w_wr_bad;
  logic                 r_en_write, r_buf_rst;
  logic [OM_ADDR_W-1:0] r_find;
  logic                 r_rsp_valid, r_rsp_hit;
  logic [COUNT_W-1:0]   r_count;
  logic                 r_wrapped;
  logic [CNT_W-1:0]     r_err;

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_clr_pend;
    w_chk_ready = 1'b0;
    case (r_state)
      IDLE: begin
        if (clear_i || r_clr_pend) begin
          w_state_nxt = CLEAR;
        end else begin
          w_chk_ready = r_live;
          if (r_live && chk_valid_i) w_state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        w_state_nxt = RESP;
        if (clear_i) w_pend_nxt = 1'b1;
      end
      RESP: begin
        if (rsp_ready_i) begin
          w_state_nxt = (r_clr_pend || clear_i) ? CLEAR : IDLE;
          w_pend_nxt  = 1'b0;
        end else if (clear_i) begin
          w_pend_nxt  = 1'b1;
        end
      end
      CLEAR: begin
        w_state_nxt = IDLE;
        w_pend_nxt  = 1'b0;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_live keeps grants and ready low while in reset and for the release cycle.
  assign w_gnt_en = r_live && (r_state != CLEAR) && !r_clr_pend;

  om_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (w_gnt_en),
    .req_i  (wr_req_i),
    .gnt_o  (w_gnt)
  );

  always_comb begin
    w_wr_range = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) w_wr_range = '{first: wr_first_i[i], last: wr_last_i[i]};
    end
  end

  // A grant landing on the transition into CLEAR is dropped, never written.
  assign w_wr_any = |w_gnt;
  assign w_wr_ok  = w_wr_any && om_range_valid(w_wr_range) && (w_state_nxt != CLEAR);
  assign w_wr_bad = w_wr_any && !om_range_valid(w_wr_range);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_clr_pend  <= 1'b0;
      r_live      <= 1'b0;
      r_buf_rst   <= 1'b0;
      r_en_write  <= 1'b0;
      r_wr_range  <= '0;
      r_find      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_pend <= w_pend_nxt;
      r_live     <= 1'b1;
      r_buf_rst  <= (w_state_nxt == CLEAR);
      r_en_write <= w_wr_ok;
      if (w_wr_any) r_wr_range <= w_wr_range;
      if (w_chk_ready && chk_valid_i) r_find <= chk_addr_i;
      if (r_state == LOOKUP) begin
        r_rsp_valid <= 1'b1;
        r_rsp_hit   <= buf_addr_in_range_i;
      end else if (r_state == RESP && rsp_ready_i) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count   <= '0;
      r_wrapped <= 1'b0;
      r_err     <= '0;
    end else if (r_state == CLEAR) begin
      r_count   <= '0;
      r_wrapped <= 1'b0;
      r_err     <= '0;
    end else begin
      if (w_wr_ok) begin
        if (r_count < COUNT_W'(SIZE)) r_count <= r_count + COUNT_W'(1);
        else                          r_wrapped <= 1'b1;
      end
      if (w_wr_bad && (r_err != '1)) r_err <= r_err + CNT_W'(1);
    end
  end

  assign wr_gnt_o         = w_gnt;
  assign chk_ready_o      = w_chk_ready;
  assign rsp_valid_o      = r_rsp_valid;
  assign rsp_hit_o        = r_rsp_hit;
  assign buf_rst_us_o     = r_buf_rst;
  assign buf_en_write_o   = r_en_write;
  assign buf_addr_first_o = r_wr_range.first;
  assign buf_addr_last_o  = r_wr_range.last;
  assign buf_find_addr_o  = r_find;
  assign count_o          = r_count;
  assign wrapped_o        = r_wrapped;
  assign err_cnt_o        = r_err;

endmodule
`default_nettype wire
